// File: rtl/stream_demux_if.sv
// Stream bundle between one upstream source and the N_OUT-way demux outputs.
// slave is the demux view; master is the surrounding source/sink view.
interface stream_demux_if #(
   parameter int N_OUT = 4,
   parameter int W     = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     in_data;
   logic [3:0]       in_sel;
   logic             in_last;
   logic [N_OUT-1:0] out_valid;
   logic [N_OUT-1:0] out_ready;
   logic [W-1:0]     out_data;
   logic             out_last;

   modport master (
      output in_valid, in_data, in_sel, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  in_valid, in_data, in_sel, in_last, out_ready,
      output in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/stream_demux.sv
// Packet-locked 1:N_OUT stream demux with a single output register stage.
// Optional STREAM_DEMUX_DROP_EN: discard packets whose sel >= N_OUT and count them in drop_cnt.
module stream_demux #(
   parameter int N_OUT = 4,
   parameter int W     = 8
) (
   input  logic          clk,
   input  logic          rst,
   stream_demux_if.slave bus
`ifdef STREAM_DEMUX_DROP_EN
   ,
   output logic [7:0]    drop_cnt
`endif
);
   typedef enum logic {IDLE, LOCKED} state_t;

   state_t       state_q, state_d;
   logic [3:0]   lock_dest_q;
   logic [3:0]   cur_dest;
   logic         cur_drop;
   logic         accept;
   logic         load;
   logic         deliver;
   logic [W-1:0] data_p1;
   logic         last_p1;
   logic [3:0]   dest_p1;
   logic         vld_p1;
`ifdef STREAM_DEMUX_DROP_EN
   logic         lock_drop_q;
   logic         sel_oob;
`endif

   // Out-of-range selects collapse onto the highest port.
   function automatic logic [3:0] map_sel(input logic [3:0] sel);
      if ({1'b0, sel} >= 5'(N_OUT)) return 4'(N_OUT - 1);
      else return sel;
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

`ifdef STREAM_DEMUX_DROP_EN
   assign sel_oob = ({1'b0, bus.in_sel} >= 5'(N_OUT));
`endif

   always_comb begin
      deliver       = 1'b0;
      bus.out_valid = '0;
      for (int i = 0; i < N_OUT; i++) begin
         if (vld_p1 && dest_p1 == 4'(i)) begin
            bus.out_valid[i] = 1'b1;
            deliver          = bus.out_ready[i];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      cur_dest = lock_dest_q;
`ifdef STREAM_DEMUX_DROP_EN
      cur_drop = lock_drop_q;
`else
      cur_drop = 1'b0;
`endif
      if (state_q == IDLE) begin
         cur_dest = map_sel(bus.in_sel);
`ifdef STREAM_DEMUX_DROP_EN
         cur_drop = sel_oob;
`endif
      end
      // Discarded beats never touch the register, so they are always taken.
      bus.in_ready = cur_drop || !vld_p1 || deliver;
      accept       = bus.in_valid && bus.in_ready;
      load         = accept && !cur_drop;
      if (accept) state_d = bus.in_last ? IDLE : LOCKED;
   end

   // Stage p1: output register and packet lock
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         lock_dest_q <= 4'd0;
         vld_p1      <= 1'b0;
         data_p1     <= '0;
         last_p1     <= 1'b0;
         dest_p1     <= 4'd0;
`ifdef STREAM_DEMUX_DROP_EN
         lock_drop_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         if (accept && state_q == IDLE) begin
            lock_dest_q <= cur_dest;
`ifdef STREAM_DEMUX_DROP_EN
            lock_drop_q <= cur_drop;
`endif
         end
         if (load) begin
            vld_p1  <= 1'b1;
            data_p1 <= bus.in_data;
            last_p1 <= bus.in_last;
            dest_p1 <= cur_dest;
         end else if (deliver) begin
            vld_p1  <= 1'b0;
         end
      end
   end

`ifdef STREAM_DEMUX_DROP_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) drop_cnt <= 8'd0;
      else if (accept && cur_drop && bus.in_last) drop_cnt <= sat_inc(drop_cnt);
   end
`endif

   assign bus.out_data = data_p1;
   assign bus.out_last = last_p1;
endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: directed vector table, reset/corner sequences and a
// randomized run checked against a queue-based packet model.
module tb_stream_demux;
   localparam int N = 4;
`ifdef STREAM_DEMUX_DROP_EN
   localparam bit DROP_EN = 1'b1;
`else
   localparam bit DROP_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [7:0] drop_cnt;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   stream_demux_if #(.N_OUT(N), .W(8)) bus ();

   stream_demux #(.N_OUT(N), .W(8)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
`ifdef STREAM_DEMUX_DROP_EN
      ,
      .drop_cnt(drop_cnt)
`endif
   );

`ifndef STREAM_DEMUX_DROP_EN
   assign drop_cnt = 8'd0;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: beats held for delivery, plus the current packet's routing.
   typedef struct { logic [7:0] data; logic last; int port; } beat_t;
   beat_t exp_q[$];
   bit    m_first = 1'b1;
   int    m_port  = 0;
   bit    m_drop  = 1'b0;
   int    m_drops = 0;

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         m_first = 1'b1;
         m_drops = 0;
         chk("rst_in_ready", 32'(bus.in_ready), 1);
         chk("rst_out_valid", 32'(bus.out_valid), 0);
         chk("rst_out_data", 32'(bus.out_data), 0);
         if (DROP_EN) chk("rst_drop_cnt", 32'(drop_cnt), 0);
      end else begin
         bit sel_oob, cur_drop, exp_ir, deliv, acc;
         logic [N-1:0] exp_ov;
         sel_oob  = (int'(bus.in_sel) >= N);
         cur_drop = m_first ? (DROP_EN && sel_oob) : m_drop;
         deliv    = (exp_q.size() > 0) && bus.out_ready[exp_q[0].port];
         exp_ir   = cur_drop || (exp_q.size() == 0) || deliv;
         exp_ov   = '0;
         if (exp_q.size() > 0) exp_ov[exp_q[0].port] = 1'b1;
         chk("mdl_in_ready", 32'(bus.in_ready), 32'(exp_ir));
         chk("mdl_out_valid", 32'(bus.out_valid), 32'(exp_ov));
         chk("mdl_onehot", 32'($countones(bus.out_valid) <= 1), 1);
         if (exp_q.size() > 0) begin
            chk("mdl_out_data", 32'(bus.out_data), 32'(exp_q[0].data));
            chk("mdl_out_last", 32'(bus.out_last), 32'(exp_q[0].last));
         end
         if (DROP_EN) chk("mdl_drop_cnt", 32'(drop_cnt), 32'(m_drops));
         acc = bus.in_valid && exp_ir;
         if (deliv) void'(exp_q.pop_front());
         if (acc) begin
            if (m_first) begin
               m_drop = DROP_EN && sel_oob;
               m_port = sel_oob ? N - 1 : int'(bus.in_sel);
            end
            if (!m_drop) exp_q.push_back('{bus.in_data, bus.in_last, m_port});
            else if (bus.in_last && m_drops < 255) m_drops++;
            m_first = bus.in_last;
         end
      end
   end

   typedef struct {
      logic v; logic [7:0] d; logic [3:0] s; logic l; logic [3:0] ordy;
      logic ir; logic [3:0] ov; logic [7:0] od;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input logic v, input logic [7:0] d, input logic [3:0] s, input logic l,
                      input logic [3:0] ordy, input logic ir, input logic [3:0] ov, input logic [7:0] od);
      tbl.push_back('{v, d, s, l, ordy, ir, ov, od});
   endtask

   task automatic drive(input logic v, input logic [7:0] d, input logic [3:0] s, input logic l,
                        input logic [3:0] ordy);
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.in_sel    = s;
      bus.in_last   = l;
      bus.out_ready = ordy;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      drive(1'b0, 8'h00, 4'd0, 1'b0, 4'h0);

      // single beat, then 3-beat packet locked to port 1 despite later sel=3
      add(1, 8'hA5, 2, 1, 4'hF, 1, 4'b0000, 8'h00);
      add(1, 8'h11, 1, 0, 4'hF, 1, 4'b0100, 8'hA5);
      add(1, 8'h22, 3, 0, 4'hF, 1, 4'b0010, 8'h11);
      add(1, 8'h33, 3, 1, 4'hF, 1, 4'b0010, 8'h22);
      add(0, 8'h00, 0, 0, 4'hF, 1, 4'b0010, 8'h33);
      add(0, 8'h00, 0, 0, 4'hF, 1, 4'b0000, 8'h00);
      // 5-cycle stall on port 1 while other ports' ready toggles
      add(1, 8'h41, 1, 0, 4'hD, 1, 4'b0000, 8'h00);
      add(1, 8'h42, 0, 0, 4'hD, 0, 4'b0010, 8'h41);
      add(1, 8'h42, 0, 0, 4'hD, 0, 4'b0010, 8'h41);
      add(1, 8'h42, 0, 0, 4'h0, 0, 4'b0010, 8'h41);
      add(1, 8'h42, 0, 0, 4'h5, 0, 4'b0010, 8'h41);
      add(1, 8'h42, 0, 0, 4'hC, 0, 4'b0010, 8'h41);
      add(1, 8'h42, 0, 0, 4'hF, 1, 4'b0010, 8'h41);
      add(1, 8'h43, 2, 0, 4'hF, 1, 4'b0010, 8'h42);
      add(1, 8'h44, 2, 1, 4'hF, 1, 4'b0010, 8'h43);
      add(0, 8'h00, 0, 0, 4'hF, 1, 4'b0010, 8'h44);
      add(0, 8'h00, 0, 0, 4'hF, 1, 4'b0000, 8'h00);
      // 2-beat packet with sel=7
      add(1, 8'h71, 7, 0, 4'hF, 1, 4'b0000, 8'h00);
      if (DROP_EN) begin
         add(1, 8'h72, 7, 1, 4'hF, 1, 4'b0000, 8'h00);
         add(0, 8'h00, 0, 0, 4'hF, 1, 4'b0000, 8'h00);
      end else begin
         add(1, 8'h72, 7, 1, 4'hF, 1, 4'b1000, 8'h71);
         add(0, 8'h00, 0, 0, 4'hF, 1, 4'b1000, 8'h72);
      end
      add(0, 8'h00, 0, 0, 4'hF, 1, 4'b0000, 8'h00);

      @(posedge clk); #1;
      chk("reset_out_valid", 32'(bus.out_valid), 0);
      chk("reset_in_ready", 32'(bus.in_ready), 1);
      chk("reset_out_last", 32'(bus.out_last), 0);
      @(posedge clk); #2;
      rst = 1'b0;

      foreach (tbl[i]) begin
         @(posedge clk); #1;
         drive(tbl[i].v, tbl[i].d, tbl[i].s, tbl[i].l, tbl[i].ordy);
         @(negedge clk);
         chk($sformatf("tbl%0d_in_ready", i), 32'(bus.in_ready), 32'(tbl[i].ir));
         chk($sformatf("tbl%0d_out_valid", i), 32'(bus.out_valid), 32'(tbl[i].ov));
         if (tbl[i].ov != 4'b0000)
            chk($sformatf("tbl%0d_out_data", i), 32'(bus.out_data), 32'(tbl[i].od));
      end
      if (DROP_EN) chk("drop_cnt_after_sel7", 32'(drop_cnt), 1);

      // reset in the middle of a 4-beat packet to port 1
      @(posedge clk); #1; drive(1, 8'h81, 4'd1, 1'b0, 4'hF);
      @(posedge clk); #1; drive(1, 8'h82, 4'd2, 1'b0, 4'hF);
      @(posedge clk); #1; drive(0, 8'h00, 4'd0, 1'b0, 4'hF);
      #1;
      chk("pre_rst_out_valid", 32'(bus.out_valid), 32'(4'b0010));
      #1; rst = 1'b1;
      #1;
      chk("async_rst_out_valid", 32'(bus.out_valid), 0);
      chk("async_rst_in_ready", 32'(bus.in_ready), 1);
      @(posedge clk); #2; rst = 1'b0;
      @(posedge clk); #1; drive(1, 8'h90, 4'd0, 1'b0, 4'hF);
      @(posedge clk); #1; drive(1, 8'h91, 4'd2, 1'b1, 4'hF);
      #1;
      chk("post_rst_port0_a", 32'(bus.out_valid), 32'(4'b0001));
      chk("post_rst_data_a", 32'(bus.out_data), 32'h90);
      @(posedge clk); #1; drive(0, 8'h00, 4'd0, 1'b0, 4'hF);
      #1;
      chk("post_rst_port0_b", 32'(bus.out_valid), 32'(4'b0001));
      chk("post_rst_data_b", 32'(bus.out_data), 32'h91);

      // random traffic: first sel 0/3 with full backpressure toggling, then unconstrained
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         bus.in_valid = ($urandom % 4) != 0;
         bus.in_data  = 8'($urandom);
         bus.in_last  = ($urandom % 3) == 0;
         if (c < 600) begin
            bus.in_sel    = ($urandom % 2) ? 4'd3 : 4'd0;
            bus.out_ready = (c % 2) ? 4'hF : 4'h0;
         end else begin
            bus.in_sel    = 4'($urandom);
            bus.out_ready = 4'($urandom);
         end
      end
      @(posedge clk); #1; drive(0, 8'h00, 4'd0, 1'b0, 4'hF);
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("drained_out_valid", 32'(bus.out_valid), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 The block SHALL have parameter N_OUT, default 4, giving the number of output ports (2..16).
REQ-002 The block SHALL have parameter W, default 8, giving the data width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: an upstream beat is offered.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts the beat this cycle.
REQ-007 The block SHALL have port in_data, input, W bits: the beat payload.
REQ-008 The block SHALL have port in_sel, input, 4 bits: the destination port index.
REQ-009 The block SHALL have port in_last, input, 1 bit: the final beat of a packet.
REQ-010 The block SHALL have port out_valid, output, N_OUT bits: one-hot, a beat is presented to that port.
REQ-011 The block SHALL have port out_ready, input, N_OUT bits: per-port downstream ready.
REQ-012 The block SHALL have port out_data, output, W bits: shared payload bus for all ports.
REQ-013 The block SHALL have port out_last, output, 1 bit: the presented beat is the last of its packet.

Function
REQ-014 The block SHALL treat a beat as accepted when in_valid and in_ready are both 1, and as delivered when out_valid[d] and out_ready[d] are both 1 for the held destination d.
REQ-015 The block SHALL hold one output register (data, last, destination, full flag); an accepted beat SHALL appear on out_valid/out_data/out_last exactly 1 cycle later.
REQ-016 The block SHALL drive in_ready = !full OR (delivery this cycle), giving one beat per cycle when the destination stays ready.
REQ-017 The block SHALL set at most one out_valid bit, and only while full = 1.
REQ-018 The block SHALL keep out_data, out_last and out_valid stable while out_valid[d] = 1 and out_ready[d] = 0.
REQ-019 The block SHALL implement a two-state FSM: in IDLE, an accepted beat samples in_sel as the packet destination and moves to LOCKED if in_last = 0, otherwise stays in IDLE.
REQ-020 In LOCKED, the block SHALL ignore in_sel, route every beat to the locked destination, and return to IDLE on acceptance of a beat with in_last = 1.
REQ-021 The block SHALL handle a single-beat packet (first beat with in_last = 1) entirely in IDLE.
REQ-022 The block SHALL NOT change in_ready, out_data, out_last or out_valid in response to out_ready bits of non-destination ports.
REQ-023 The block SHALL drop no beat and duplicate no beat when acceptance and delivery occur in the same cycle.

Reset
REQ-024 On rst = 1, the block SHALL immediately (asynchronously) set the FSM to IDLE, full to 0, out_valid to all zeros, out_data to 0, out_last to 0 and the locked destination to 0; in_ready SHALL then read 1.
REQ-025 The block SHALL abandon a packet interrupted by reset mid-packet; the first beat accepted after reset SHALL be treated as a new packet first beat.

Configuration
REQ-026 When STREAM_DEMUX_DROP_EN is defined, the block SHALL accept and discard every beat of a packet whose sampled in_sel >= N_OUT, never asserting out_valid for those beats, with in_ready = 1 while discarding.
REQ-027 When STREAM_DEMUX_DROP_EN is defined, the block SHALL provide an 8-bit output drop_cnt, reset to 0, that increments once per discarded packet (at its last beat) and saturates at 255.
REQ-028 When STREAM_DEMUX_DROP_EN is not defined, the block SHALL route packets with in_sel >= N_OUT to port N_OUT-1, and port drop_cnt SHALL NOT exist.

Verification
REQ-029 Reset, then a single beat with sel=2, data=0xA5, last=1 and all out_ready=1 -> out_valid=4'b0100 and out_data=0xA5 one cycle later, for one cycle.
REQ-030 A 3-beat packet 0x11/0x22/0x33 with sel=1 on beat 0 and sel=3 on beats 1-2 -> all three beats delivered on port 1, in order, at 1 beat per cycle.
REQ-031 Stall with out_ready[1]=0 for 5 cycles mid-packet -> in_ready=0 after the register fills, output held stable, no loss; on release the remaining beats are delivered in order.
REQ-032 Assert rst mid-packet after beat 2 of 4 -> out_valid=0 at once; a next packet with sel=0 is routed to port 0.
REQ-033 Back-to-back packets to sel=0 then sel=3 with full backpressure toggling -> each packet appears only on its own port; out_valid is never multi-hot.
REQ-034 With STREAM_DEMUX_DROP_EN defined, a 2-beat packet with sel=7 and N_OUT=4 -> no out_valid, drop_cnt goes 0->1; without the macro, the same packet is delivered on port 3.
